// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronizer, mid-bit sampling, optional parity,
// one or two stop bits, and a WAIT_HI state that holds off restarts on a broken line.
module uart_rx_cfg #(
    parameter int CLK_DIV   = 5208,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BAUD_MAX  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_MAX  = CW'(CLK_DIV / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PAR     = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_WAIT_HI = 3'd5;

    logic                 sync1_q, sync2_q, rxs;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 ferr_pend_q, ferr_pend_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 ferr_now;

    assign rxs = sync2_q;

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        perr_pend_d  = perr_pend_q;
        ferr_pend_d  = ferr_pend_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        ferr_now     = ferr_pend_q | ~rxs;
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    baud_d  = '0;
                end
            end
            S_START: begin
                if (baud_q == HALF_MAX) begin
                    baud_d      = '0;
                    bit_d       = '0;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                    // A start bit that is high again at its centre was only a glitch.
                    state_d     = rxs ? S_IDLE : S_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_PAR: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d      = '0;
                    bit_d       = '0;
                    perr_pend_d = ((^shift_q) ^ rxs) != ODD;
                    state_d     = S_STOP;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d        = '0;
                        rx_data_d    = shift_q;
                        rx_valid_d   = 1'b1;
                        parity_err_d = perr_pend_q;
                        frame_err_d  = ferr_now;
                        // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                        state_d      = ferr_now ? S_WAIT_HI : S_IDLE;
                    end else begin
                        bit_d       = bit_q + 4'd1;
                        ferr_pend_d = ferr_now;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_WAIT_HI: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_pend_q  <= 1'b0;
            ferr_pend_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_pend_q  <= perr_pend_d;
            ferr_pend_q  <= ferr_pend_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE);
endmodule
